hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush decisions, ALU forwarding selects,
// mul/div stall sequencing and a saturating stall-cycle counter.
//
// Ports:
//   clk, clrn                  clock, synchronous active-low reset
//   id_rs, id_rt               source registers of the ID instruction
//   id_use_rs, id_use_rt       ID instruction reads rs / rt
//   id_branch_taken, id_jump   control transfer resolved in ID
//   ex_wreg, ex_m2reg, ex_rn   EX writeback enable / load / destination
//   ex_md_start, ex_md_div     EX holds mul/div, 1 = divide
//   mem_wreg, mem_m2reg, mem_rn MEM writeback enable / load / destination
//   stall                      freeze PC and IF/ID
//   id_bubble                  load NOP into ID/EX
//   if_flush                   zero the fetched instruction
//   md_busy, md_done           mul/div FSM busy / last stall cycle
//   fwda, fwdb                 operand select (00 rf, 01 EX, 10 MEM alu, 11 MEM load)
//   stall_cnt                  saturating count of stalled cycles

module hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_branch_taken,
    input  logic        id_jump,
    input  logic        ex_wreg,
    input  logic        ex_m2reg,
    input  logic [4:0]  ex_rn,
    input  logic        ex_md_start,
    input  logic        ex_md_div,
    input  logic        mem_wreg,
    input  logic        mem_m2reg,
    input  logic [4:0]  mem_rn,
    output logic        stall,
    output logic        id_bubble,
    output logic        if_flush,
    output logic        md_busy,
    output logic        md_done,
    output logic [1:0]  fwda,
    output logic [1:0]  fwdb,
    output logic [15:0] stall_cnt
);

    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    md_state_t   state_q;
    md_state_t   state_d;
    logic [5:0]  cnt_q;
    logic [5:0]  cnt_d;
    logic [15:0] stall_cnt_q;

    logic        md_stall;
    logic        md_busy_i;
    logic        md_done_i;
    logic        lu;
    logic        stall_i;
    logic        bubble_i;
    logic        flush_i;
    logic [1:0]  fwda_i;
    logic [1:0]  fwdb_i;

    // Forward select for one source register. EX wins over MEM; a load
    // still in EX has no data yet, so it is never an EX forwarding source.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (ex_wreg && !ex_m2reg && (ex_rn != 5'd0) && (ex_rn == src)) begin
            sel = 2'b01;
        end else if (mem_wreg && (mem_rn != 5'd0) && (mem_rn == src)) begin
            sel = mem_m2reg ? 2'b11 : 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        fwda_i = fwd_sel(id_rs);
        fwdb_i = fwd_sel(id_rt);
    end

    always_comb begin
        lu = 1'b0;
        if (ex_wreg && ex_m2reg && (ex_rn != 5'd0)) begin
            lu = (id_use_rs && (ex_rn == id_rs))
               || (id_use_rt && (ex_rn == id_rt));
        end
    end

    // Mul/div FSM: state register
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Mul/div FSM: next state. The first stall cycle is the IDLE cycle in
    // which the request is seen, so the counter loads N-1 and BUSY lasts
    // N-1 cycles, ending on cnt==1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (ex_md_start) begin
                    state_d = BUSY;
                    cnt_d   = ex_md_div ? DIV_LOAD : MUL_LOAD;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    // Mul/div FSM: outputs
    always_comb begin
        md_stall  = 1'b0;
        md_busy_i = 1'b0;
        md_done_i = 1'b0;
        unique case (state_q)
            IDLE: begin
                md_stall = ex_md_start;
            end
            BUSY: begin
                md_stall  = 1'b1;
                md_busy_i = 1'b1;
                md_done_i = (cnt_q == 6'd1);
            end
            default: begin
                md_stall = 1'b0;
            end
        endcase
    end

    // A stalled branch is replayed, so it must not flush until it resolves
    // on a non-stalled cycle.
    always_comb begin
        stall_i  = md_stall | lu;
        bubble_i = lu & ~md_stall;
        flush_i  = (id_branch_taken | id_jump) & ~stall_i;
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            stall_cnt_q <= 16'd0;
        end else if (stall_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    // Everything is held quiet while reset is asserted.
    always_comb begin
        stall     = clrn & stall_i;
        id_bubble = clrn & bubble_i;
        if_flush  = clrn & flush_i;
        md_busy   = clrn & md_busy_i;
        md_done   = clrn & md_done_i;
        fwda      = clrn ? fwda_i : 2'b00;
        fwdb      = clrn ? fwdb_i : 2'b00;
        stall_cnt = clrn ? stall_cnt_q : 16'd0;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.

module tb_hazard_ctrl;

    logic        clk;
    logic        clrn;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_branch_taken;
    logic        id_jump;
    logic        ex_wreg;
    logic        ex_m2reg;
    logic [4:0]  ex_rn;
    logic        ex_md_start;
    logic        ex_md_div;
    logic        mem_wreg;
    logic        mem_m2reg;
    logic [4:0]  mem_rn;
    logic        stall;
    logic        id_bubble;
    logic        if_flush;
    logic        md_busy;
    logic        md_done;
    logic [1:0]  fwda;
    logic [1:0]  fwdb;
    logic [15:0] stall_cnt;

    int checks;
    int failures;

    hazard_ctrl #(
        .MUL_CYCLES(4),
        .DIV_CYCLES(32)
    ) dut (
        .clk(clk),
        .clrn(clrn),
        .id_rs(id_rs),
        .id_rt(id_rt),
        .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt),
        .id_branch_taken(id_branch_taken),
        .id_jump(id_jump),
        .ex_wreg(ex_wreg),
        .ex_m2reg(ex_m2reg),
        .ex_rn(ex_rn),
        .ex_md_start(ex_md_start),
        .ex_md_div(ex_md_div),
        .mem_wreg(mem_wreg),
        .mem_m2reg(mem_m2reg),
        .mem_rn(mem_rn),
        .stall(stall),
        .id_bubble(id_bubble),
        .if_flush(if_flush),
        .md_busy(md_busy),
        .md_done(md_done),
        .fwda(fwda),
        .fwdb(fwdb),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs           = 5'd0;
        id_rt           = 5'd0;
        id_use_rs       = 1'b0;
        id_use_rt       = 1'b0;
        id_branch_taken = 1'b0;
        id_jump         = 1'b0;
        ex_wreg         = 1'b0;
        ex_m2reg        = 1'b0;
        ex_rn           = 5'd0;
        ex_md_start     = 1'b0;
        ex_md_div       = 1'b0;
        mem_wreg        = 1'b0;
        mem_m2reg       = 1'b0;
        mem_rn          = 5'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, {15'd0, stall}, 16'd0);
        chk({tag, "_bubble"}, {15'd0, id_bubble}, 16'd0);
        chk({tag, "_flush"}, {15'd0, if_flush}, 16'd0);
        chk({tag, "_busy"}, {15'd0, md_busy}, 16'd0);
        chk({tag, "_done"}, {15'd0, md_done}, 16'd0);
        chk({tag, "_fwda"}, {14'd0, fwda}, 16'd0);
        chk({tag, "_fwdb"}, {14'd0, fwdb}, 16'd0);
        chk({tag, "_cnt"}, stall_cnt, 16'd0);
    endtask

    task automatic do_reset();
        idle_inputs();
        clrn = 1'b0;
        next_cycle();
        clrn = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();
        clrn = 1'b0;
        #1;

        // Reset with mul/div request, load-use and jump all active.
        ex_md_start = 1'b1;
        ex_wreg     = 1'b1;
        ex_m2reg    = 1'b1;
        ex_rn       = 5'd8;
        id_rt       = 5'd8;
        id_use_rt   = 1'b1;
        id_jump     = 1'b1;
        mem_wreg    = 1'b1;
        mem_rn      = 5'd8;
        sample();
        chk_all_zero("rst0");
        next_cycle();
        sample();
        chk_all_zero("rst1");
        next_cycle();
        clrn = 1'b1;
        idle_inputs();
        sample();
        chk_all_zero("post_rst");

        // Forwarding priority and register 0.
        next_cycle();
        ex_wreg  = 1'b1;
        mem_wreg = 1'b1;
        ex_rn    = 5'd5;
        mem_rn   = 5'd5;
        id_rs    = 5'd5;
        id_rt    = 5'd5;
        sample();
        chk("fwd_ex_a", {14'd0, fwda}, 16'h1);
        chk("fwd_ex_b", {14'd0, fwdb}, 16'h1);
        next_cycle();
        ex_wreg = 1'b0;
        sample();
        chk("fwd_mem_a", {14'd0, fwda}, 16'h2);
        next_cycle();
        mem_m2reg = 1'b1;
        sample();
        chk("fwd_load_a", {14'd0, fwda}, 16'h3);
        next_cycle();
        ex_wreg = 1'b1;
        ex_rn   = 5'd0;
        mem_rn  = 5'd0;
        id_rs   = 5'd0;
        id_rt   = 5'd0;
        sample();
        chk("fwd_r0_a", {14'd0, fwda}, 16'h0);
        chk("fwd_r0_b", {14'd0, fwdb}, 16'h0);
        // A load in EX is not a source; MEM ALU result is used instead.
        next_cycle();
        idle_inputs();
        ex_wreg  = 1'b1;
        ex_m2reg = 1'b1;
        ex_rn    = 5'd5;
        mem_wreg = 1'b1;
        mem_rn   = 5'd5;
        id_rs    = 5'd5;
        id_rt    = 5'd6;
        sample();
        chk("fwd_exload_a", {14'd0, fwda}, 16'h2);
        chk("fwd_exload_b", {14'd0, fwdb}, 16'h0);
        chk("fwd_nouse_stall", {15'd0, stall}, 16'h0);
        chk("fwd_cnt", stall_cnt, 16'h0);

        // Load-use stall suppresses the jump flush.
        next_cycle();
        idle_inputs();
        ex_wreg   = 1'b1;
        ex_m2reg  = 1'b1;
        ex_rn     = 5'd8;
        id_rt     = 5'd8;
        id_use_rt = 1'b1;
        id_jump   = 1'b1;
        sample();
        chk("lu_stall", {15'd0, stall}, 16'h1);
        chk("lu_bubble", {15'd0, id_bubble}, 16'h1);
        chk("lu_flush", {15'd0, if_flush}, 16'h0);
        chk("lu_fwdb", {14'd0, fwdb}, 16'h0);
        next_cycle();
        ex_wreg   = 1'b0;
        ex_m2reg  = 1'b0;
        ex_rn     = 5'd0;
        mem_wreg  = 1'b1;
        mem_m2reg = 1'b1;
        mem_rn    = 5'd8;
        sample();
        chk("lu2_fwdb", {14'd0, fwdb}, 16'h3);
        chk("lu2_stall", {15'd0, stall}, 16'h0);
        chk("lu2_flush", {15'd0, if_flush}, 16'h1);
        chk("lu2_cnt", stall_cnt, 16'h1);

        // Multiply: 4 stall cycles.
        next_cycle();
        do_reset();
        ex_md_start = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            if (c == 4) ex_md_start = 1'b0;
            sample();
            chk($sformatf("mul_stall_c%0d", c), {15'd0, stall},
                {15'd0, c <= 3});
            chk($sformatf("mul_busy_c%0d", c), {15'd0, md_busy},
                {15'd0, c >= 1 && c <= 3});
            chk($sformatf("mul_done_c%0d", c), {15'd0, md_done},
                {15'd0, c == 3});
            next_cycle();
        end
        sample();
        chk("mul_cnt", stall_cnt, 16'd4);

        // Divide followed immediately by a multiply.
        next_cycle();
        do_reset();
        ex_md_start = 1'b1;
        ex_md_div   = 1'b1;
        for (int c = 0; c <= 36; c++) begin
            if (c == 32) ex_md_div = 1'b0;
            if (c == 36) ex_md_start = 1'b0;
            if (c == 5) begin
                ex_wreg         = 1'b1;
                ex_m2reg        = 1'b1;
                ex_rn           = 5'd9;
                id_rs           = 5'd9;
                id_use_rs       = 1'b1;
                id_branch_taken = 1'b1;
            end
            if (c == 6) begin
                ex_wreg         = 1'b0;
                ex_m2reg        = 1'b0;
                id_branch_taken = 1'b0;
            end
            sample();
            chk($sformatf("div_stall_c%0d", c), {15'd0, stall},
                {15'd0, c <= 35});
            chk($sformatf("div_busy_c%0d", c), {15'd0, md_busy},
                {15'd0, c != 0 && c != 32 && c <= 35});
            chk($sformatf("div_done_c%0d", c), {15'd0, md_done},
                {15'd0, c == 31 || c == 35});
            if (c == 5) begin
                chk("div_lu_bubble", {15'd0, id_bubble}, 16'h0);
                chk("div_lu_flush", {15'd0, if_flush}, 16'h0);
            end
            next_cycle();
        end
        sample();
        chk("div_cnt", stall_cnt, 16'd36);

        // Reset in the middle of a divide aborts it.
        next_cycle();
        do_reset();
        ex_md_start = 1'b1;
        ex_md_div   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 1) ex_md_start = 1'b0;
            next_cycle();
        end
        clrn = 1'b0;
        sample();
        chk_all_zero("div_abort_rst");
        next_cycle();
        clrn = 1'b1;
        for (int c = 0; c < 30; c++) begin
            sample();
            chk($sformatf("abort_busy_%0d", c), {15'd0, md_busy}, 16'h0);
            chk($sformatf("abort_done_%0d", c), {15'd0, md_done}, 16'h0);
            next_cycle();
        end
        sample();
        chk("abort_cnt", stall_cnt, 16'd0);

        // Saturation of the stall counter.
        next_cycle();
        do_reset();
        ex_wreg   = 1'b1;
        ex_m2reg  = 1'b1;
        ex_rn     = 5'd3;
        id_rs     = 5'd3;
        id_use_rs = 1'b1;
        repeat (65534) next_cycle();
        sample();
        chk("sat_fffe", stall_cnt, 16'hFFFE);
        next_cycle();
        sample();
        chk("sat_ffff", stall_cnt, 16'hFFFF);
        repeat (4466) next_cycle();
        sample();
        chk("sat_hold", stall_cnt, 16'hFFFF);
        chk("sat_stall", {15'd0, stall}, 16'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
